// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage: RV32I load/store opcodes, funct3 codes
// and the access FSM state type.
package mem_access_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

endpackage

// File: rtl/mem_access_stage_load_data_align.sv
// Moves the addressed byte/halfword of a raw read word down to bit 0 and
// sign- or zero-extends it according to the load funct3.
module load_data_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  data = {24'h0, shifted[7:0]};
            F3_LHU:  data = {16'h0, shifted[15:0]};
            F3_LW:   data = shifted;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the RV32I pipeline: issues one valid/ready data-memory access
// per load/store, stalls upstream until it completes, and registers results to WB.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned addrWidth = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [addrWidth-1:0] pc_in,
    input  logic [31:0]          inst_in,
    input  logic [31:0]          alu_out_in,
    input  logic [31:0]          rs2_rdata_in,
    output logic                 stall_out,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [addrWidth-1:0] dmem_addr,
    output logic [3:0]           dmem_wstrb,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_ready,
    input  logic [31:0]          dmem_rdata,
    output logic                 wb_valid,
    output logic [addrWidth-1:0] wb_pc,
    output logic [31:0]          wb_inst,
    output logic [31:0]          wb_data,
    output logic                 mem_fault
);

    state_e               state_q, state_d;
    logic                 dmem_req_q, dmem_req_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [addrWidth-1:0] dmem_addr_q, dmem_addr_d;
    logic [3:0]           dmem_wstrb_q, dmem_wstrb_d;
    logic [31:0]          dmem_wdata_q, dmem_wdata_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [addrWidth-1:0] wb_pc_q, wb_pc_d;
    logic [31:0]          wb_inst_q, wb_inst_d;
    logic [31:0]          wb_data_q, wb_data_d;
    logic                 mem_fault_q, mem_fault_d;

    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic        is_load, is_store, fault, mem_op;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata, ld_data;

    load_data_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (funct3),
        .offset (offset),
        .data   (ld_data)
    );

    always_comb begin
        funct3   = inst_in[14:12];
        offset   = alu_out_in[1:0];
        is_load  = (inst_in[6:0] == OP_LOAD);
        is_store = (inst_in[6:0] == OP_STORE);
        fault    = 1'b0;
        st_wstrb = '0;
        st_wdata = '0;
        if (is_load) begin
            case (funct3)
                F3_LB, F3_LBU: fault = 1'b0;
                F3_LH, F3_LHU: fault = offset[0];
                F3_LW:         fault = (offset != 2'b00);
                default:       fault = 1'b1;
            endcase
        end else if (is_store) begin
            case (funct3)
                F3_SB: begin
                    fault    = 1'b0;
                    st_wstrb = 4'b0001 << offset;
                    st_wdata = {4{rs2_rdata_in[7:0]}};
                end
                F3_SH: begin
                    fault    = offset[0];
                    st_wstrb = 4'b0011 << offset;
                    st_wdata = {2{rs2_rdata_in[15:0]}};
                end
                F3_SW: begin
                    fault    = (offset != 2'b00);
                    st_wstrb = 4'b1111;
                    st_wdata = rs2_rdata_in;
                end
                default: fault = 1'b1;
            endcase
        end
        mem_op    = (is_load || is_store) && !fault;
        stall_out = ((state_q == IDLE) && mem_op) || (state_q == BUSY);
    end

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wstrb_d = dmem_wstrb_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_pc_d      = wb_pc_q;
        wb_inst_d    = '0;
        wb_data_d    = wb_data_q;
        mem_fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d      = BUSY;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_store;
                    dmem_addr_d  = {alu_out_in[addrWidth-1:2], 2'b00};
                    dmem_wstrb_d = is_store ? st_wstrb : 4'b0000;
                    dmem_wdata_d = is_store ? st_wdata : 32'h0;
                end else begin
                    wb_valid_d  = 1'b1;
                    wb_pc_d     = pc_in;
                    wb_inst_d   = inst_in;
                    wb_data_d   = fault ? 32'h0 : alu_out_in;
                    mem_fault_d = fault;
                end
            end
            BUSY: begin
                // Request stays asserted with its payload untouched until the handshake.
                if (dmem_ready) begin
                    state_d    = DONE;
                    dmem_req_d = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_pc_d    = pc_in;
                    wb_inst_d  = inst_in;
                    wb_data_d  = is_load ? ld_data : alu_out_in;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wstrb_q <= '0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_pc_q      <= '0;
            wb_inst_q    <= '0;
            wb_data_q    <= '0;
            mem_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wstrb_q <= dmem_wstrb_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_pc_q      <= wb_pc_d;
            wb_inst_q    <= wb_inst_d;
            wb_data_q    <= wb_data_d;
            mem_fault_q  <= mem_fault_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wstrb = dmem_wstrb_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_pc      = wb_pc_q;
    assign wb_inst    = wb_inst_q;
    assign wb_data    = wb_data_q;
    assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a table of single ops with hand-computed
// results, plus hand-written back-to-back and reset-during-access sequences.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic [31:0] inst_in, alu_out_in, rs2_rdata_in;
    logic        stall_out, dmem_req, dmem_we, dmem_ready;
    logic [15:0] dmem_addr, wb_pc;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata, dmem_rdata, wb_inst, wb_data;
    logic        wb_valid, mem_fault;

    mem_access_stage #(.addrWidth(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .inst_in      (inst_in),
        .alu_out_in   (alu_out_in),
        .rs2_rdata_in (rs2_rdata_in),
        .stall_out    (stall_out),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_inst      (wb_inst),
        .wb_data      (wb_data),
        .mem_fault    (mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] inst, alu, rs2, rdata;
        int unsigned delay;
        bit          mem, we, fault;
        logic [15:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata, data;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_vec = 0, n_miss = 0;
    bit          mon_en = 1'b0;
    int unsigned req_cycles = 0, wbv_cycles = 0;

    // Counts request and writeback cycles during the back-to-back sequence.
    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            if (dmem_req) req_cycles++;
            if (wb_valid) wbv_cycles++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t nm(input logic [15:0] pc, input logic [31:0] inst, input logic [31:0] alu,
                                input logic [31:0] data, input bit fault);
        vec_t v;
        v = '{default: 0};
        v.pc = pc; v.inst = inst; v.alu = alu; v.data = data; v.fault = fault;
        return v;
    endfunction

    function automatic vec_t st(input logic [15:0] pc, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rs2, input int unsigned delay, input logic [15:0] addr,
                                input logic [3:0] wstrb, input logic [31:0] wdata);
        vec_t v;
        v = '{default: 0};
        v.pc = pc; v.inst = {17'h0, f3, 5'h0, OP_STORE}; v.alu = alu; v.rs2 = rs2;
        v.delay = delay; v.mem = 1'b1; v.we = 1'b1; v.addr = addr; v.wstrb = wstrb;
        v.wdata = wdata; v.data = alu;
        return v;
    endfunction

    function automatic vec_t ld(input logic [15:0] pc, input logic [2:0] f3, input logic [31:0] alu,
                                input logic [31:0] rdata, input int unsigned delay, input logic [15:0] addr,
                                input logic [31:0] data);
        vec_t v;
        v = '{default: 0};
        v.pc = pc; v.inst = {17'h0, f3, 5'h0, OP_LOAD}; v.alu = alu; v.rdata = rdata;
        v.delay = delay; v.mem = 1'b1; v.addr = addr; v.data = data;
        return v;
    endfunction

    // Called at a falling edge while the DUT is idle; returns at a falling edge while idle.
    task automatic run_vec(input vec_t v);
        pc_in = v.pc; inst_in = v.inst; alu_out_in = v.alu; rs2_rdata_in = v.rs2;
        dmem_rdata = v.rdata; dmem_ready = 1'b0;
        #1 chk("stall_issue", {31'h0, stall_out}, {31'h0, v.mem});
        if (!v.mem) begin
            @(negedge clk);
            chk("nm_wb_valid", {31'h0, wb_valid}, 32'h1);
            chk("nm_wb_pc", {16'h0, wb_pc}, {16'h0, v.pc});
            chk("nm_wb_inst", wb_inst, v.inst);
            chk("nm_wb_data", wb_data, v.data);
            chk("nm_fault", {31'h0, mem_fault}, {31'h0, v.fault});
            chk("nm_no_req", {31'h0, dmem_req}, 32'h0);
        end else begin
            @(negedge clk);
            chk("busy_req", {31'h0, dmem_req}, 32'h1);
            chk("busy_we", {31'h0, dmem_we}, {31'h0, v.we});
            chk("busy_addr", {16'h0, dmem_addr}, {16'h0, v.addr});
            chk("busy_wstrb", {28'h0, dmem_wstrb}, {28'h0, v.wstrb});
            if (v.we) chk("busy_wdata", dmem_wdata, v.wdata);
            chk("busy_stall", {31'h0, stall_out}, 32'h1);
            chk("busy_wb_valid", {31'h0, wb_valid}, 32'h0);
            for (int unsigned k = 0; k < v.delay; k++) begin
                @(negedge clk);
                chk("wait_req", {31'h0, dmem_req}, 32'h1);
                chk("wait_addr", {16'h0, dmem_addr}, {16'h0, v.addr});
                chk("wait_stall", {31'h0, stall_out}, 32'h1);
                chk("wait_wb_valid", {31'h0, wb_valid}, 32'h0);
            end
            dmem_ready = 1'b1;
            @(negedge clk);
            dmem_ready = 1'b0;
            chk("done_wb_valid", {31'h0, wb_valid}, 32'h1);
            chk("done_wb_pc", {16'h0, wb_pc}, {16'h0, v.pc});
            chk("done_wb_inst", wb_inst, v.inst);
            chk("done_wb_data", wb_data, v.data);
            chk("done_fault", {31'h0, mem_fault}, 32'h0);
            chk("done_req", {31'h0, dmem_req}, 32'h0);
            chk("done_stall", {31'h0, stall_out}, 32'h0);
            inst_in = 32'h0; alu_out_in = 32'h0; pc_in = 16'h0;
            @(negedge clk);
            chk("idle_wb_valid", {31'h0, wb_valid}, 32'h0);
            chk("idle_req", {31'h0, dmem_req}, 32'h0);
        end
    endtask

    initial begin
        vecs.push_back(nm(16'h0010, 32'h002081B3, 32'h00000005, 32'h00000005, 1'b0));
        vecs.push_back(nm(16'h0014, 32'h00001003, 32'h00000001, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h0018, 32'h00002003, 32'h00000102, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h001C, 32'h00001023, 32'h00000003, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h0020, 32'h00002023, 32'h00000001, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h0024, 32'h00003003, 32'h00000100, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h0028, 32'h00003023, 32'h00000100, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h002C, 32'h00006003, 32'h00000100, 32'h00000000, 1'b1));
        vecs.push_back(nm(16'h0030, 32'h00008093, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0));
        vecs.push_back(st(16'h0100, F3_SB, 32'h00000102, 32'h000000AB, 0, 16'h0100, 4'b0100, 32'hABABABAB));
        vecs.push_back(st(16'h0104, F3_SH, 32'h00000006, 32'h1234CAFE, 0, 16'h0004, 4'b1100, 32'hCAFECAFE));
        vecs.push_back(st(16'h0108, F3_SW, 32'h00000010, 32'h89ABCDEF, 1, 16'h0010, 4'b1111, 32'h89ABCDEF));
        vecs.push_back(ld(16'h0200, F3_LB, 32'h00000203, 32'h80FF1234, 2, 16'h0200, 32'hFFFFFF80));
        vecs.push_back(ld(16'h0204, F3_LBU, 32'h00000203, 32'h80FF1234, 2, 16'h0200, 32'h00000080));
        vecs.push_back(ld(16'h0208, F3_LH, 32'h00000002, 32'h80FF1234, 0, 16'h0000, 32'hFFFF80FF));
        vecs.push_back(ld(16'h020C, F3_LHU, 32'h00000002, 32'h80FF1234, 0, 16'h0000, 32'h000080FF));
        vecs.push_back(ld(16'h0210, F3_LH, 32'h00000000, 32'h80FF1234, 0, 16'h0000, 32'h00001234));
        vecs.push_back(ld(16'h0214, F3_LW, 32'h00000FFC, 32'h80FF1234, 0, 16'h0FFC, 32'h80FF1234));
        vecs.push_back(ld(16'h0218, F3_LB, 32'hABCD0001, 32'h80FF1234, 0, 16'h0000, 32'h00000012));
        vecs.push_back(ld(16'h021C, F3_LB, 32'h00000302, 32'h80FF1234, 1, 16'h0300, 32'hFFFFFFFF));

        rst = 1'b1; pc_in = '0; inst_in = '0; alu_out_in = '0; rs2_rdata_in = '0;
        dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, dmem_req}, 32'h0);
        chk("rst_we_wstrb", {27'h0, dmem_we, dmem_wstrb}, 32'h0);
        chk("rst_addr", {16'h0, dmem_addr}, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_wb_pc", {16'h0, wb_pc}, 32'h0);
        chk("rst_wb_inst", wb_inst, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_fault", {31'h0, mem_fault}, 32'h0);

        // LW then SW straight out of reset, each with immediate ready.
        rst = 1'b0; mon_en = 1'b1;
        pc_in = 16'h0040; inst_in = 32'h00002003; alu_out_in = 32'h00000020; dmem_rdata = 32'h13579BDF;
        #1 chk("b2b_lw_stall", {31'h0, stall_out}, 32'h1);
        @(negedge clk);
        chk("b2b_lw_req", {30'h0, dmem_req, dmem_we}, 32'h2);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("b2b_lw_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("b2b_lw_wb_data", wb_data, 32'h13579BDF);
        chk("b2b_lw_wb_inst", wb_inst, 32'h00002003);
        pc_in = 16'h0044; inst_in = 32'h00002023; alu_out_in = 32'h00000024; rs2_rdata_in = 32'h2468ACE0;
        @(negedge clk);
        chk("b2b_gap_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("b2b_gap_req", {31'h0, dmem_req}, 32'h0);
        chk("b2b_sw_stall", {31'h0, stall_out}, 32'h1);
        @(negedge clk);
        chk("b2b_sw_req", {30'h0, dmem_req, dmem_we}, 32'h3);
        chk("b2b_sw_addr", {16'h0, dmem_addr}, 32'h00000024);
        chk("b2b_sw_wdata", dmem_wdata, 32'h2468ACE0);
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("b2b_sw_wb_valid", {31'h0, wb_valid}, 32'h1);
        chk("b2b_sw_wb_inst", wb_inst, 32'h00002023);
        chk("b2b_sw_wb_data", wb_data, 32'h00000024);
        inst_in = 32'h0; alu_out_in = 32'h0; pc_in = 16'h0;
        @(negedge clk);
        mon_en = 1'b0;
        chk("b2b_end_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("b2b_req_cycles", req_cycles, 32'd2);
        chk("b2b_wb_cycles", wbv_cycles, 32'd2);

        // Reset while an access is outstanding abandons it.
        pc_in = 16'h0300; inst_in = {17'h0, F3_LB, 5'h0, OP_LOAD}; alu_out_in = 32'h00000203;
        @(negedge clk);
        chk("rb_req", {31'h0, dmem_req}, 32'h1);
        rst = 1'b1; inst_in = 32'h0; alu_out_in = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        chk("rb_req_after", {31'h0, dmem_req}, 32'h0);
        chk("rb_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rb_stall", {31'h0, stall_out}, 32'h0);
        @(negedge clk);
        chk("rb_req_stays_low", {31'h0, dmem_req}, 32'h0);

        foreach (vecs[i]) run_vec(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
